// File: rtl/pwm_mmio_if.sv
// Core data-memory store/load bus as seen by a memory-mapped peripheral.
// The core drives address, lanes and strobes; the peripheral returns load data.
interface pwm_mmio_if;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic [31:0] write_data;
  logic        mem_read;
  logic [31:0] read_data;

  modport master (
    output address, byte_en, write_data, mem_read,
    input  read_data
  );

  modport slave (
    input  address, byte_en, write_data, mem_read,
    output read_data
  );
endinterface

// File: rtl/pwm_mmio.sv
// Memory-mapped complementary PWM with double-buffered period/duty, dead-time
// protected high/low gate drive and a sticky period-wrap interrupt flag.
module pwm_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  pwm_mmio_if.slave  bus,
  output logic       pwm_hi,
  output logic       pwm_lo,
  output logic       period_irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_DT_LH,
    S_HI,
    S_DT_HL
  } state_e;

  logic             en_q, en_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic [DT_W-1:0]  deadtime_q, deadtime_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_e           state_q;
  logic [DT_W-1:0]  dt_cnt_q;
  logic             hi_q, lo_q;

  logic             base_hit, sel_ctrl, sel_period, sel_duty, sel_dt, sel_status;
  logic             irq_clr, wrap, en_rise, raw;
  logic [4:0]       offset;
  logic             unused_bus_bits;

  assign offset     = bus.address[4:0];
  assign base_hit   = (bus.address[31:5] == BASE_ADDR[31:5]);
  assign sel_ctrl   = base_hit && (offset == 5'h00);
  assign sel_period = base_hit && (offset == 5'h04);
  assign sel_duty   = base_hit && (offset == 5'h08);
  assign sel_dt     = base_hit && (offset == 5'h0C);
  assign sel_status = base_hit && (offset == 5'h10);

  // Registers are at most 16 bits wide, so the upper store lanes are never used.
  assign unused_bus_bits = ^{bus.write_data[31:16], bus.byte_en[3:2]};

  assign wrap    = en_q && (cnt_q == period_act_q);
  assign en_rise = !en_q && en_d;
  assign raw     = en_q && (cnt_q < duty_act_q);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    en_d        = en_q;
    irq_clr     = 1'b0;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    deadtime_d  = deadtime_q;

    if (sel_ctrl && bus.byte_en[0]) begin
      en_d    = bus.write_data[0];
      irq_clr = bus.write_data[1];
    end
    if (sel_period) begin
      if (bus.byte_en[0]) period_sh_d[7:0]  = bus.write_data[7:0];
      if (bus.byte_en[1]) period_sh_d[15:8] = bus.write_data[15:8];
    end
    if (sel_duty) begin
      if (bus.byte_en[0]) duty_sh_d[7:0]  = bus.write_data[7:0];
      if (bus.byte_en[1]) duty_sh_d[15:8] = bus.write_data[15:8];
    end
    if (sel_dt && bus.byte_en[0]) deadtime_d = bus.write_data[DT_W-1:0];
  end

  // Shadow values are taken before this edge's store lands, so a store on the
  // wrap edge only applies from the following wrap.
  always_comb begin
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    if (wrap || en_rise) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end

    if (!en_q || wrap) cnt_d = '0;
    else               cnt_d = cnt_q + 1'b1;

    // A wrap on the same edge as a clear keeps the flag set.
    if (wrap)         irq_d = 1'b1;
    else if (irq_clr) irq_d = 1'b0;
    else              irq_d = irq_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q         <= 1'b0;
      irq_q        <= 1'b0;
      period_sh_q  <= '0;
      duty_sh_q    <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      deadtime_q   <= '0;
      cnt_q        <= '0;
    end else begin
      en_q         <= en_d;
      irq_q        <= irq_d;
      period_sh_q  <= period_sh_d;
      duty_sh_q    <= duty_sh_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      deadtime_q   <= deadtime_d;
      cnt_q        <= cnt_d;
    end
  end

  // Gate FSM; the gate outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dt_cnt_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else if (!en_q) begin
      state_q <= S_IDLE;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_LO;
          hi_q    <= 1'b0;
          lo_q    <= 1'b1;
        end
        S_LO: begin
          if (raw) begin
            lo_q <= 1'b0;
            if (deadtime_q == '0) begin
              state_q <= S_HI;
              hi_q    <= 1'b1;
            end else begin
              state_q  <= S_DT_LH;
              dt_cnt_q <= deadtime_q - 1'b1;
            end
          end
        end
        S_DT_LH: begin
          if (!raw) begin
            state_q <= S_LO;
            lo_q    <= 1'b1;
          end else if (dt_cnt_q == '0) begin
            state_q <= S_HI;
            hi_q    <= 1'b1;
          end else begin
            dt_cnt_q <= dt_cnt_q - 1'b1;
          end
        end
        S_HI: begin
          if (!raw) begin
            hi_q <= 1'b0;
            if (deadtime_q == '0) begin
              state_q <= S_LO;
              lo_q    <= 1'b1;
            end else begin
              state_q  <= S_DT_HL;
              dt_cnt_q <= deadtime_q - 1'b1;
            end
          end
        end
        S_DT_HL: begin
          if (raw) begin
            state_q <= S_HI;
            hi_q    <= 1'b1;
          end else if (dt_cnt_q == '0) begin
            state_q <= S_LO;
            lo_q    <= 1'b1;
          end else begin
            dt_cnt_q <= dt_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          hi_q    <= 1'b0;
          lo_q    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.read_data = 32'h0;
    if (bus.mem_read) begin
      if (sel_ctrl)   bus.read_data = {31'h0, en_q};
      if (sel_period) bus.read_data = {{(32-CNT_W){1'b0}}, period_sh_q};
      if (sel_duty)   bus.read_data = {{(32-CNT_W){1'b0}}, duty_sh_q};
      if (sel_dt)     bus.read_data = {{(32-DT_W){1'b0}}, deadtime_q};
      if (sel_status) bus.read_data = {cnt_q, 14'h0, en_q, irq_q};
    end
  end

  assign pwm_hi     = hi_q;
  assign pwm_lo     = lo_q;
  assign period_irq = irq_q;

endmodule

// File: tb/tb_pwm_mmio.sv
// Randomised scoreboard bench for pwm_mmio: a behavioural model predicts gates,
// irq and load data; a monitor compares on the falling edge.
module tb_pwm_mmio;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int NONE = 0, LO = 1, HI = 2;

  logic clk = 1'b0;
  logic reset;
  logic pwm_hi, pwm_lo, period_irq;
  always #5 clk = ~clk;

  pwm_mmio_if bus ();

  pwm_mmio #(.BASE_ADDR(BASE), .CNT_W(16), .DT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_irq(period_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register file, a period counter and, for the gates, the
  // side currently driven plus how long raw has been asking for the other side.
  bit          m_en, m_irq, m_hi, m_lo;
  logic [15:0] m_psh, m_dsh, m_pact, m_dact, m_cnt;
  logic [7:0]  m_dt;
  int          side, run, snap;

  logic [2:0]  out_q [$];
  logic [31:0] rd_q  [$];

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    case (a[4:0])
      5'h00:   return {31'h0, m_en};
      5'h04:   return {16'h0, m_psh};
      5'h08:   return {16'h0, m_dsh};
      5'h0C:   return {24'h0, m_dt};
      5'h10:   return {m_cnt, 14'h0, m_en, m_irq};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit raw, wrap, clr, en_n;
    logic [15:0] psh_n, dsh_n;
    logic [7:0] dt_n;
    int want;
    if (reset) begin
      m_en = 0; m_irq = 0; m_hi = 0; m_lo = 0;
      m_psh = 0; m_dsh = 0; m_pact = 0; m_dact = 0; m_cnt = 0; m_dt = 0;
      side = NONE; run = 0; snap = 0;
      return;
    end
    raw  = m_en && (m_cnt < m_dact);
    wrap = m_en && (m_cnt == m_pact);

    if (!m_en) begin
      side = NONE; run = 0;
    end else if (side == NONE) begin
      side = LO; run = 0;
    end else begin
      want = raw ? HI : LO;
      if (want == side) run = 0;
      else begin
        run++;
        if (run == 1) snap = int'(m_dt);
        if (run > snap) begin
          side = want; run = 0;
        end
      end
    end

    en_n = m_en; clr = 0; psh_n = m_psh; dsh_n = m_dsh; dt_n = m_dt;
    if (bus.address[31:5] == BASE[31:5]) begin
      case (bus.address[4:0])
        5'h00: if (bus.byte_en[0]) begin en_n = bus.write_data[0]; clr = bus.write_data[1]; end
        5'h04: begin
          if (bus.byte_en[0]) psh_n[7:0]  = bus.write_data[7:0];
          if (bus.byte_en[1]) psh_n[15:8] = bus.write_data[15:8];
        end
        5'h08: begin
          if (bus.byte_en[0]) dsh_n[7:0]  = bus.write_data[7:0];
          if (bus.byte_en[1]) dsh_n[15:8] = bus.write_data[15:8];
        end
        5'h0C: if (bus.byte_en[0]) dt_n = bus.write_data[7:0];
        default: ;
      endcase
    end

    if (wrap || (!m_en && en_n)) begin
      m_pact = m_psh; m_dact = m_dsh;
    end
    m_cnt = (m_en && !wrap) ? m_cnt + 16'd1 : 16'd0;
    if (wrap) m_irq = 1;
    else if (clr) m_irq = 0;
    m_en = en_n; m_psh = psh_n; m_dsh = dsh_n; m_dt = dt_n;
    m_hi = (side == HI) && (run == 0);
    m_lo = (side == LO) && (run == 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    out_q.push_back({m_hi, m_lo, m_irq});
  end

  initial forever begin
    logic [2:0] e;
    @(negedge clk);
    if (out_q.size() > 0) begin
      e = out_q.pop_front();
      check("pwm_hi", {31'h0, pwm_hi}, {31'h0, e[2]});
      check("pwm_lo", {31'h0, pwm_lo}, {31'h0, e[1]});
      check("period_irq", {31'h0, period_irq}, {31'h0, e[0]});
      check("gate_overlap", {31'h0, pwm_hi & pwm_lo}, 32'h0);
    end
    if (bus.mem_read) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL read_queue: got a load with no expected value at %0t", $time);
      end else begin
        check("read_data", bus.read_data, rd_q.pop_front());
      end
    end
  end

  task automatic cyc(logic [31:0] a, logic [3:0] be, logic [31:0] wd, logic rd, logic rst = 1'b0);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.address    = a;
    bus.byte_en    = be;
    bus.write_data = wd;
    bus.mem_read   = rd;
    if (rd) rd_q.push_back(model_read(a));
  endtask

  task automatic idle(int n);
    repeat (n) cyc(32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(logic [4:0] off, logic [31:0] d, logic [3:0] be = 4'hF);
    cyc(BASE + {27'h0, off}, be, d, 1'b0);
  endtask

  task automatic rd(logic [4:0] off);
    cyc(BASE + {27'h0, off}, 4'h0, 32'h0, 1'b1);
  endtask

  task automatic wait_cnt(logic [15:0] v);
    int k = 0;
    while (m_cnt != v && k < 100) begin
      idle(1);
      k++;
    end
    if (k == 100) begin
      n_checks++; n_fail++;
      $display("FAIL wait_cnt: counter never reached %0d", v);
    end
  endtask

  task automatic count_gates(int n, output int hi, output int lo);
    hi = 0; lo = 0;
    repeat (n) begin
      idle(1);
      hi += int'(pwm_hi);
      lo += int'(pwm_lo);
    end
  endtask

  initial begin
    int h, l;
    logic [4:0] offs [8] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
    reset = 1'b1;
    bus.address = '0; bus.byte_en = '0; bus.write_data = '0; bus.mem_read = 1'b0;
    repeat (2) cyc(32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 5; i++) rd(offs[i]);
    check("reset_hi", {31'h0, pwm_hi}, 32'h0);
    check("reset_lo", {31'h0, pwm_lo}, 32'h0);

    wr(5'h04, 32'd9); wr(5'h08, 32'd3); wr(5'h0C, 32'd0); wr(5'h00, 32'd1);
    idle(20);
    count_gates(10, h, l);
    check("dt0_hi_width", h, 3);
    check("dt0_lo_width", l, 7);

    wr(5'h0C, 32'd2); idle(20);
    count_gates(10, h, l);
    check("dt2_hi_width", h, 1);
    check("dt2_lo_width", l, 5);

    wr(5'h0C, 32'd4); idle(20);
    count_gates(10, h, l);
    check("dt4_hi_width", h, 0);
    check("dt4_lo_width", l, 7);

    wr(5'h0C, 32'd0); idle(20);
    wait_cnt(16'd3);
    wr(5'h08, 32'd7);
    rd(5'h10);
    wait_cnt(16'd9);
    count_gates(10, h, l);
    check("duty7_hi_width", h, 7);

    rd(5'h10);
    wr(5'h00, 32'h3, 4'b0001);
    idle(1);
    wait_cnt(16'd2);
    wr(5'h00, 32'h3, 4'b0001);
    idle(1);
    check("irq_cleared", {31'h0, period_irq}, 32'h0);
    wait_cnt(16'd8);
    wr(5'h00, 32'h3, 4'b0001);
    idle(1);
    check("irq_clear_on_wrap", {31'h0, period_irq}, 32'h1);
    rd(5'h10);

    wr(5'h08, 32'd0); idle(25);
    count_gates(10, h, l);
    check("duty0_lo", l, 10);
    wr(5'h08, 32'd12); idle(25);
    count_gates(10, h, l);
    check("duty12_hi", h, 10);

    wait_cnt(16'd8);
    wr(5'h00, 32'h0, 4'b0001);
    idle(3);
    wr(5'h08, 32'd3); wr(5'h00, 32'h1); idle(15);

    cyc(32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    rd(5'h10);
    check("rst_mid_hi", {31'h0, pwm_hi}, 32'h0);
    check("rst_mid_lo", {31'h0, pwm_lo}, 32'h0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] a, d;
      logic [4:0] off;
      r   = $urandom_range(0, 99);
      off = offs[$urandom_range(0, 7)];
      a   = BASE + {27'h0, off};
      if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_0100;
      if (r < 2) begin
        cyc(32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
      end else if (r < 30) begin
        d = $urandom;
        if (off == 5'h00) d[0] = ($urandom_range(0, 9) != 0);
        if (off == 5'h04 || off == 5'h08) d[15:0] = 16'($urandom_range(0, 24));
        if (off == 5'h0C) d[7:0] = 8'($urandom_range(0, 5));
        cyc(a, 4'($urandom_range(1, 15)), d, 1'b0);
      end else if (r < 55) begin
        cyc(a, 4'h0, 32'h0, 1'b1);
      end else begin
        idle(1);
      end
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
